dm_cache_ctrl: RTL and testbench
================================

// Module: dm_cache_ctrl
// PURPOSE
//   Direct-mapped, write-through, read-allocate word cache between multi_cycle_mips and async_mem.
//   Adds a cpu_ready handshake so the CPU can stall; hits complete in 1 cycle.
//   Misses and writes go to async_mem with a fixed MEM_LAT-cycle access window,
//   which covers the memory's combinational read delay.
// PARAMETERS
//   INDEX_BITS  6  line index width; 2**INDEX_BITS one-word lines
//   MEM_LAT     4  cycles mem_read is held before mem_read_data is sampled (>=1)
// PORTS
//   clk             in   1   system clock, all flops on posedge
//   reset           in   1   asynchronous, active-low reset
//   cpu_addr        in   32  byte address; [1:0] ignored
//   cpu_read        in   1   read request, held until cpu_ready
//   cpu_write       in   1   write request, held until cpu_ready
//   cpu_write_data  in   32  store data
//   cpu_read_data   out  32  load data, valid while cpu_ready=1
//   cpu_ready       out  1   1-cycle pulse: request completed
//   mem_addr        out  32  word-aligned address to async_mem
//   mem_read        out  1   memory read enable
//   mem_write       out  1   memory write enable (sampled on posedge by memory)
//   mem_write_data  out  32  store data to memory
//   mem_read_data   in   32  memory read data
// BEHAVIOUR
//   Address split: idx=cpu_addr[INDEX_BITS+1:2], tag=cpu_addr[31:INDEX_BITS+2].
//   Storage: valid[], tag[], data[] per line; only valid[] is reset.
//   FSM states and transitions:
//     IDLE: read hit -> RESP; read miss -> FILL (cnt=0); write -> WR; none -> IDLE
//     FILL: mem_read=1, mem_addr={cpu_addr[31:2],2'b00}; cnt++ each cycle.
//           At cnt==MEM_LAT-1: write data/tag into line, set valid -> RESP
//     WR: mem_write=1 for exactly 1 cycle; update data if tag hits (no allocate) -> RESP
//     RESP: cpu_ready=1; cpu_read_data=data[idx] -> IDLE
//   Latency: read hit 2 cycles request->ready; miss MEM_LAT+2; write 3.
//   cpu_read & cpu_write both 1: treated as write; read is ignored.
//   Request must stay stable until cpu_ready. Back-to-back requests are accepted
//   in the IDLE cycle following RESP.
//   Reset (low): FSM->IDLE, all valid=0, cpu_ready/mem_read/mem_write=0
//     immediately (async); cnt=0. An aborted fill leaves its line invalid.
//   Outputs when idle: mem_addr=0, mem_write_data=0, cpu_read_data=0.
// CONFIGURATION
//   CACHE_STATS_EN defined: adds outputs hit_count[31:0], miss_count[31:0].
//     Both counters are reset to 0 and wrap at 2**32.
//     +1 on IDLE->RESP read hit (hit) / IDLE->FILL (miss); writes not counted.
//   Not defined: no counters and no extra ports; behaviour otherwise identical.
// STRUCTURE
//   Package mips_mem_pkg: state enum (IDLE,FILL,WR,RESP), WORD_W=32, addr-slice helpers.
//   Sub-module cache_line_store: valid/tag/data arrays, combinational lookup
//     (hit, rdata), single write port with set-valid control; valid cleared on reset.
//   The top level holds the FSM, latency counter, memory-side muxing, and optional stats.
// TESTING
//   Reset then read 0x100 (mem=0xDEADBEEF): mem_read high 4 cycles, ready at cycle 6, data DEADBEEF
//   Reread 0x100: no mem_read, ready 2 cycles later, data DEADBEEF; hit_count=1, miss_count=1
//   Write 0x100=0x12345678: one mem_write pulse, mem updated; reread hits, returns 12345678
//   Read 0x100 then 0x200 (same idx, INDEX_BITS=6): second misses, evicts; third read of 0x100 misses
//   Assert reset low mid-FILL (cnt=2): mem_read drops at once; read after reset misses again
//   cpu_read & cpu_write both 1 at 0x40: write performed, no fill, ready at cycle 3

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and address helpers for the MIPS memory path (cache controller and line store).
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WR,
        RESP
    } state_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & ~32'd3;
    endfunction

    // Word address: byte address with the two offset bits dropped.
    function automatic logic [WORD_W-3:0] word_index(input logic [WORD_W-1:0] a);
        return (WORD_W-2)'(a >> 2);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: valid/tag/data arrays, combinational lookup, one write port.
module cache_line_store
    import mips_mem_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = WORD_W - 2 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] idx,
    input  logic [TAG_W-1:0]      tag,
    output logic                  hit,
    output logic [WORD_W-1:0]     rdata,
    input  logic                  we,
    input  logic                  set_valid,
    input  logic [WORD_W-1:0]     wdata
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];

    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign rdata = data_q[idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid_q <= '0;
        else if (we && set_valid)
            valid_q[idx] <= 1'b1;
    end

    // Tag and data are only meaningful behind valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= wdata;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through read-allocate word cache with a cpu_ready stall handshake.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module dm_cache_ctrl
    import mips_mem_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int MEM_LAT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [WORD_W-1:0] cpu_write_data,
    output logic [WORD_W-1:0] cpu_read_data,
    output logic              cpu_ready,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_write_data,
    input  logic [WORD_W-1:0] mem_read_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int TAG_W = WORD_W - 2 - INDEX_BITS;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [WORD_W-3:0]       waddr;
    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit, fill_done, st_we;
    logic [WORD_W-1:0]       st_rdata, st_wdata;

    assign waddr = word_index(cpu_addr);
    assign idx   = waddr[INDEX_BITS-1:0];
    assign tag   = waddr[WORD_W-3:INDEX_BITS];

    // Fill allocates and sets valid; a write only refreshes a line it already hits.
    assign fill_done = (state == FILL) && (cnt == CNT_LAST);
    assign st_we     = fill_done || ((state == WR) && hit);
    assign st_wdata  = fill_done ? mem_read_data : cpu_write_data;

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx),
        .tag       (tag),
        .hit       (hit),
        .rdata     (st_rdata),
        .we        (st_we),
        .set_valid (fill_done),
        .wdata     (st_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_write)
                    state_nxt = WR;
                else if (cpu_read)
                    state_nxt = hit ? RESP : FILL;
            end
            FILL:    if (cnt == CNT_LAST) state_nxt = RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready      = 1'b0;
        cpu_read_data  = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state)
            FILL: begin
                mem_read = 1'b1;
                mem_addr = word_align(cpu_addr);
            end
            WR: begin
                mem_write      = 1'b1;
                mem_addr       = word_align(cpu_addr);
                mem_write_data = cpu_write_data;
            end
            RESP: begin
                cpu_ready     = 1'b1;
                cpu_read_data = st_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (state == FILL)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

`ifdef CACHE_STATS_EN
    // Only reads are counted; a simultaneous read+write is a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu_read && !cpu_write) begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            else
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a behavioural async_mem model.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
    logic        cpu_read, cpu_write, cpu_ready;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int passed = 0;
    int rd_cycles = 0;
    int wr_pulses = 0;

    logic [31:0] mem_arr [0:1023];

    dm_cache_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_ready      (cpu_ready),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial forever #5 clk = ~clk;

    assign mem_read_data = mem_read ? mem_arr[mem_addr[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr[11:2]] <= mem_write_data;
    end

    always @(posedge clk) begin
        if (mem_read)  rd_cycles++;
        if (mem_write) wr_pulses++;
    end

    // Latency = posedges until cpu_ready is visible, plus the edge that completes it.
    task automatic do_req(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rdat);
        @(negedge clk);
        cpu_addr = a; cpu_read = rd; cpu_write = wr; cpu_write_data = wd;
        rd_cycles = 0; wr_pulses = 0;
        lat = -1; rdat = 32'h0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (cpu_ready) begin
                lat  = i + 1;
                rdat = cpu_read_data;
                break;
            end
        end
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h0; cpu_write_data = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_addr = 32'h0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_write_data = 32'h0;
        #12;
        checks++; if (cpu_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", cpu_ready); else passed++;
        checks++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read got %b exp 0", mem_read); else passed++;
        checks++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write got %b exp 0", mem_write); else passed++;
        checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else passed++;
        checks++; if (cpu_read_data !== 32'h0) $display("FAIL reset_rdata got %h exp 0", cpu_read_data); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_read_miss();
        int lat; logic [31:0] d;
        do_req(32'h100, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 6) $display("FAIL miss_latency got %0d exp 6", lat); else passed++;
        checks++; if (rd_cycles !== 4) $display("FAIL miss_mem_read_cycles got %0d exp 4", rd_cycles); else passed++;
        checks++; if (d !== 32'hDEADBEEF) $display("FAIL miss_data got %h exp deadbeef", d); else passed++;
    endtask

    task automatic test_read_hit();
        int lat; logic [31:0] d;
        do_req(32'h100, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 2) $display("FAIL hit_latency got %0d exp 2", lat); else passed++;
        checks++; if (rd_cycles !== 0) $display("FAIL hit_mem_read_cycles got %0d exp 0", rd_cycles); else passed++;
        checks++; if (d !== 32'hDEADBEEF) $display("FAIL hit_data got %h exp deadbeef", d); else passed++;
`ifdef CACHE_STATS_EN
        checks++; if (hit_count !== 32'd1) $display("FAIL hit_count got %0d exp 1", hit_count); else passed++;
        checks++; if (miss_count !== 32'd1) $display("FAIL miss_count got %0d exp 1", miss_count); else passed++;
`endif
    endtask

    task automatic test_idle_outputs();
        @(negedge clk);
        checks++; if (mem_addr !== 32'h0) $display("FAIL idle_mem_addr got %h exp 0", mem_addr); else passed++;
        checks++; if (mem_write_data !== 32'h0) $display("FAIL idle_mem_wdata got %h exp 0", mem_write_data); else passed++;
        checks++; if (cpu_read_data !== 32'h0) $display("FAIL idle_rdata got %h exp 0", cpu_read_data); else passed++;
    endtask

    task automatic test_write();
        int lat; logic [31:0] d;
        do_req(32'h100, 1'b0, 1'b1, 32'h12345678, lat, d);
        checks++; if (lat !== 3) $display("FAIL write_latency got %0d exp 3", lat); else passed++;
        checks++; if (wr_pulses !== 1) $display("FAIL write_pulses got %0d exp 1", wr_pulses); else passed++;
        checks++; if (mem_arr[64] !== 32'h12345678) $display("FAIL write_mem got %h exp 12345678", mem_arr[64]); else passed++;
        do_req(32'h100, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 2) $display("FAIL write_reread_latency got %0d exp 2", lat); else passed++;
        checks++; if (d !== 32'h12345678) $display("FAIL write_reread_data got %h exp 12345678", d); else passed++;
    endtask

    task automatic test_evict();
        int lat; logic [31:0] d;
        do_req(32'h200, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 6) $display("FAIL evict_0x200_latency got %0d exp 6", lat); else passed++;
        checks++; if (d !== 32'hCAFEF00D) $display("FAIL evict_0x200_data got %h exp cafef00d", d); else passed++;
        do_req(32'h100, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 6) $display("FAIL evict_0x100_latency got %0d exp 6", lat); else passed++;
        checks++; if (d !== 32'h12345678) $display("FAIL evict_0x100_data got %h exp 12345678", d); else passed++;
    endtask

    task automatic test_reset_mid_fill();
        int lat; logic [31:0] d;
        @(negedge clk);
        cpu_addr = 32'h300; cpu_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_read !== 1'b1) $display("FAIL midfill_mem_read_before got %b exp 1", mem_read); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) $display("FAIL midfill_mem_read_async got %b exp 0", mem_read); else passed++;
        checks++; if (cpu_ready !== 1'b0) $display("FAIL midfill_ready got %b exp 0", cpu_ready); else passed++;
`ifdef CACHE_STATS_EN
        checks++; if (miss_count !== 32'd0) $display("FAIL midfill_miss_count_clr got %0d exp 0", miss_count); else passed++;
`endif
        @(negedge clk);
        cpu_read = 1'b0; cpu_addr = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        do_req(32'h300, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 6) $display("FAIL midfill_reread_latency got %0d exp 6", lat); else passed++;
        checks++; if (rd_cycles !== 4) $display("FAIL midfill_reread_cycles got %0d exp 4", rd_cycles); else passed++;
        checks++; if (d !== 32'h0BADF00D) $display("FAIL midfill_reread_data got %h exp 0badf00d", d); else passed++;
    endtask

    task automatic test_read_write_both();
        int lat; logic [31:0] d;
        do_req(32'h40, 1'b1, 1'b1, 32'hA5A5A5A5, lat, d);
        checks++; if (lat !== 3) $display("FAIL both_latency got %0d exp 3", lat); else passed++;
        checks++; if (rd_cycles !== 0) $display("FAIL both_no_fill got %0d exp 0", rd_cycles); else passed++;
        checks++; if (wr_pulses !== 1) $display("FAIL both_wr_pulses got %0d exp 1", wr_pulses); else passed++;
        checks++; if (mem_arr[16] !== 32'hA5A5A5A5) $display("FAIL both_mem got %h exp a5a5a5a5", mem_arr[16]); else passed++;
        // No write-allocate: the following read must still miss.
        do_req(32'h40, 1'b1, 1'b0, 32'h0, lat, d);
        checks++; if (lat !== 6) $display("FAIL both_reread_latency got %0d exp 6", lat); else passed++;
        checks++; if (d !== 32'hA5A5A5A5) $display("FAIL both_reread_data got %h exp a5a5a5a5", d); else passed++;
`ifdef CACHE_STATS_EN
        checks++; if (miss_count !== 32'd2) $display("FAIL both_miss_count got %0d exp 2", miss_count); else passed++;
        checks++; if (hit_count !== 32'd0) $display("FAIL both_hit_count got %0d exp 0", hit_count); else passed++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h1000_0000 + i;
        mem_arr[64]  = 32'hDEADBEEF;
        mem_arr[128] = 32'hCAFEF00D;
        mem_arr[192] = 32'h0BADF00D;
        mem_arr[16]  = 32'h11111111;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_idle_outputs();
        test_write();
        test_evict();
        test_reset_mid_fill();
        test_read_write_both();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
